// File: rtl/disp_data_sel.sv
// Display-data feeder: debounces the step and mode buttons, emits a one-cycle
// CPU step pulse, cycles the display mode and registers the 16-bit display word.

module disp_data_sel_btn #(
    parameter int DEBOUNCE = 1000000
) (
    input  logic clk,
    input  logic clr,
    input  logic i_btn,
    output logic o_press
);
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;

    // A new level is accepted once it has differed for DEBOUNCE consecutive edges.
    assign w_accept = (r_s2 != r_stable) && (r_cnt == CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchronizer into one stage.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Only an accepted rising level is a press; releases stay silent.
            r_press <= w_accept && r_s2;
        end
    end

    assign o_press = r_press;
endmodule

module disp_data_sel #(
    parameter int DEBOUNCE = 1000000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        btn_step,
    input  logic        btn_mode,
    input  logic [31:0] pc,
    input  logic [31:0] next_pc,
    input  logic [4:0]  rs_addr,
    input  logic [31:0] rs_data,
    input  logic [4:0]  rt_addr,
    input  logic [31:0] rt_data,
    input  logic [31:0] alu_result,
    input  logic [31:0] db_data,
    output logic [15:0] disp_data,
    output logic        cpu_step,
    output logic [1:0]  mode
);
    logic        w_step_press;
    logic        w_mode_press;
    logic [15:0] w_sel;
    logic [1:0]  r_mode;
    logic [15:0] r_disp;
    logic        w_unused;

    disp_data_sel_btn #(.DEBOUNCE(DEBOUNCE)) u_step_btn (
        .clk     (clk),
        .clr     (clr),
        .i_btn   (btn_step),
        .o_press (w_step_press)
    );

    disp_data_sel_btn #(.DEBOUNCE(DEBOUNCE)) u_mode_btn (
        .clk     (clk),
        .clr     (clr),
        .i_btn   (btn_mode),
        .o_press (w_mode_press)
    );

    // NOTE: the default assignment before the case keeps this purely
    // combinational; a path that leaves w_sel unassigned would infer a latch.
    always_comb begin
        w_sel = {pc[7:0], next_pc[7:0]};
        case (r_mode)
            2'd1:    w_sel = {3'b000, rs_addr, rs_data[7:0]};
            2'd2:    w_sel = {3'b000, rt_addr, rt_data[7:0]};
            2'd3:    w_sel = {alu_result[7:0], db_data[7:0]};
            default: w_sel = {pc[7:0], next_pc[7:0]};
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_mode <= 2'd0;
            r_disp <= 16'h0000;
        end else begin
            if (w_mode_press) begin
                r_mode <= r_mode + 2'd1;
            end
            r_disp <= w_sel;
        end
    end

    assign disp_data = r_disp;
    assign cpu_step  = w_step_press;
    assign mode      = r_mode;

    // Only the low byte of each data bus is displayed.
    assign w_unused = &{1'b0, pc[31:8], next_pc[31:8], rs_data[31:8], rt_data[31:8],
                        alu_result[31:8], db_data[31:8]};
endmodule

// File: tb/tb_disp_data_sel.sv
// Directed self-checking bench for disp_data_sel with DEBOUNCE=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_disp_data_sel;
    logic        clk = 1'b0;
    logic        clr;
    logic        btn_step;
    logic        btn_mode;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [4:0]  rs_addr;
    logic [31:0] rs_data;
    logic [4:0]  rt_addr;
    logic [31:0] rt_data;
    logic [31:0] alu_result;
    logic [31:0] db_data;
    logic [15:0] disp_data;
    logic        cpu_step;
    logic [1:0]  mode;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses;

    disp_data_sel #(.DEBOUNCE(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .btn_step   (btn_step),
        .btn_mode   (btn_mode),
        .pc         (pc),
        .next_pc    (next_pc),
        .rs_addr    (rs_addr),
        .rs_data    (rs_data),
        .rt_addr    (rt_addr),
        .rt_data    (rt_data),
        .alu_result (alu_result),
        .db_data    (db_data),
        .disp_data  (disp_data),
        .cpu_step   (cpu_step),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected mode / display after each of five mode presses.
    logic [1:0]  exp_mode [0:5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [15:0] exp_disp [0:5] = '{16'h1A1E, 16'h039B, 16'h1144, 16'hC00F, 16'h1A1E, 16'h039B};

    initial begin
        clr        = 1'b1;
        btn_step   = 1'b0;
        btn_mode   = 1'b0;
        pc         = 32'h1A;
        next_pc    = 32'h1E;
        rs_addr    = 5'd3;
        rs_data    = 32'h9B;
        rt_addr    = 5'd17;
        rt_data    = 32'h44;
        alu_result = 32'hC0;
        db_data    = 32'h0F;

        // Reset state and first display word after release.
        tick();
        tick();
        check("rst_disp", disp_data, 16'h0000);
        check("rst_step", cpu_step, 1'b0);
        check("rst_mode", mode, 2'd0);
        clr = 1'b0;
        tick();
        check("post_rst_disp", disp_data, 16'h1A1E);

        // Clean step press: pulse only in the cycle after edge 5.
        btn_step = 1'b1;
        pulses   = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_step) pulses++;
            if (i == 4 || i == 5 || i == 6)
                check($sformatf("step_edge%0d", i), cpu_step, (i == 5) ? 1'b1 : 1'b0);
        end
        check("step_one_pulse", pulses, 1);
        btn_step = 1'b0;
        pulses   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_step) pulses++;
        end
        check("release_no_pulse", pulses, 0);
        check("step_mode_untouched", mode, 2'd0);

        // Bounce: high 2 / low 1, five times, then low.
        pulses = 0;
        for (int r = 0; r < 5; r++) begin
            btn_step = 1'b1;
            tick();
            if (cpu_step) pulses++;
            tick();
            if (cpu_step) pulses++;
            btn_step = 1'b0;
            tick();
            if (cpu_step) pulses++;
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cpu_step) pulses++;
        end
        check("bounce_no_pulse", pulses, 0);
        btn_step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_step) pulses++;
        end
        check("bounce_then_steady", pulses, 1);
        btn_step = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Mode cycling with exact latency: mode at edge 6, display at edge 7.
        for (int p = 1; p <= 5; p++) begin
            btn_mode = 1'b1;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (i == 5) check($sformatf("mode%0d_edge5", p), mode, exp_mode[p-1]);
                if (i == 6) begin
                    check($sformatf("mode%0d_edge6", p), mode, exp_mode[p]);
                    check($sformatf("disp%0d_edge6", p), disp_data, exp_disp[p-1]);
                end
                if (i == 7) check($sformatf("disp%0d_edge7", p), disp_data, exp_disp[p]);
            end
            btn_mode = 1'b0;
            for (int i = 0; i < 8; i++) tick();
        end
        check("mode_final", mode, 2'd1);

        // Data change visible after the next edge.
        rs_data = 32'h1234_56A5;
        tick();
        check("data_follow", disp_data, 16'h03A5);
        rs_data = 32'h9B;

        // Simultaneous presses.
        btn_step = 1'b1;
        btn_mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 5) begin
                check("sim_step_edge5", cpu_step, 1'b1);
                check("sim_mode_edge5", mode, 2'd1);
            end
            if (i == 6) check("sim_mode_edge6", mode, 2'd2);
        end
        btn_step = 1'b0;
        btn_mode = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("sim_mode_after_release", mode, 2'd2);

        // Reset mid-count with mode=2 clears outputs immediately.
        btn_step = 1'b1;
        tick();
        tick();
        tick();
        clr = 1'b1;
        #1;
        check("midrst_disp", disp_data, 16'h0000);
        check("midrst_mode", mode, 2'd0);
        check("midrst_step", cpu_step, 1'b0);

        // Mode button held through reset: exactly one increment after release.
        btn_step = 1'b0;
        btn_mode = 1'b1;
        pulses   = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mode != 2'd0) pulses++;
        end
        check("held_no_inc_in_rst", pulses, 0);
        clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) check("held_disp_edge0", disp_data, 16'h1A1E);
            if (i == 5) check("held_mode_edge5", mode, 2'd0);
            if (i == 6) check("held_mode_edge6", mode, 2'd1);
            if (i == 7) check("held_disp_edge7", disp_data, 16'h039B);
        end
        check("held_single_inc", mode, 2'd1);
        btn_mode = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
